// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture path: sample width, FSM encoding
// and the values the peak trackers restart from.
package adc_pkg;

    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] PEAK_MIN_INIT = '1;
    localparam logic [DATA_W-1:0] PEAK_MAX_INIT = '0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so the output never shows stale data.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture.sv
// Drives the parallel ADC conversion clock, discards its pipeline-latency
// samples after start-up, buffers captures and tracks peaks/sticky errors.
//
//   state | meaning
//   IDLE  | converter clock parked low, divider held at 0
//   FLUSH | clock running, strobes counted and discarded
//   RUN   | each strobe captures one sample
module adc_capture #(
    parameter int DATA_W     = adc_pkg::DATA_W,
    parameter int CLK_DIV    = 4,
    parameter int PIPE_LAT   = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_stats,
    output logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_otr,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    output logic              overrange,
    output logic [DATA_W-1:0] peak_max,
    output logic [DATA_W-1:0] peak_min
);

    import adc_pkg::*;

    localparam int CW = $clog2(CLK_DIV);
    localparam int FW = $clog2(PIPE_LAT + 2);
    localparam logic [CW-1:0]     CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]     CNT_HALF   = CW'(CLK_DIV / 2);
    localparam logic [FW-1:0]     FLUSH_LAST = FW'(PIPE_LAT);
    localparam logic [DATA_W-1:0] MIN_INIT   = {DATA_W{PEAK_MIN_INIT[0]}};
    localparam logic [DATA_W-1:0] MAX_INIT   = {DATA_W{PEAK_MAX_INIT[0]}};

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [FW-1:0]     flush_cnt;
    logic              strobe;
    logic              capture;
    logic              cap_valid;
    logic [DATA_W-1:0] cap_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    assign strobe  = (state != ST_IDLE) && (cnt == CNT_LAST);
    assign capture = strobe && (state == ST_RUN);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (enable) state_next = ST_FLUSH;
            ST_FLUSH: begin
                if (!enable)                       state_next = ST_IDLE;
                else if (flush_cnt == FLUSH_LAST)  state_next = ST_RUN;
            end
            ST_RUN:   if (!enable) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The divider restarts from 0 on entry so every run begins with a high phase.
    assign cnt_next = (state == ST_IDLE || state_next == ST_IDLE || cnt == CNT_LAST)
                      ? '0 : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            adc_clk   <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            adc_clk <= (state_next != ST_IDLE) && (cnt_next < CNT_HALF);
            if (state != ST_FLUSH) begin
                flush_cnt <= '0;
            end else if (strobe && flush_cnt != FLUSH_LAST) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign pop  = sample_valid && sample_ready;
    assign drop = cap_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
            peak_max  <= MAX_INIT;
            peak_min  <= MIN_INIT;
            overrange <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cap_valid <= capture;
            if (capture) begin
                cap_data  <= adc_data;
                // A capture coinciding with a clear restarts the trackers from it.
                peak_max  <= (clear_stats || adc_data > peak_max) ? adc_data : peak_max;
                peak_min  <= (clear_stats || adc_data < peak_min) ? adc_data : peak_min;
                overrange <= (overrange && !clear_stats) || adc_otr;
            end else if (clear_stats) begin
                peak_max  <= MAX_INIT;
                peak_min  <= MIN_INIT;
                overrange <= 1'b0;
            end
            overflow <= (overflow && !clear_stats) || drop;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap_valid),
        .pop   (pop),
        .din   (cap_data),
        .dout  (sample),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sample_valid = !fifo_empty;

endmodule

// File: tb/tb_adc_capture.sv
// Directed/randomized bench for adc_capture with an ADC model that presents
// one value per converter-clock period and a pop-order scoreboard.
module tb_adc_capture;

    localparam int DATA_W     = 10;
    localparam int CLK_DIV    = 4;
    localparam int PIPE_LAT   = 5;
    localparam int FIFO_DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              clear_stats;
    logic              adc_clk;
    logic [DATA_W-1:0] adc_data;
    logic              adc_otr;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
    logic              overflow;
    logic              overrange;
    logic [DATA_W-1:0] peak_max;
    logic [DATA_W-1:0] peak_min;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    int k        = 0;
    logic [DATA_W-1:0] src_mem [256];
    logic              otr_mem [256];
    logic [DATA_W-1:0] got_q [$];
    int exp_max;
    int exp_min;

    always #5 clk = ~clk;

    adc_capture #(
        .DATA_W     (DATA_W),
        .CLK_DIV    (CLK_DIV),
        .PIPE_LAT   (PIPE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_stats  (clear_stats),
        .adc_clk      (adc_clk),
        .adc_data     (adc_data),
        .adc_otr      (adc_otr),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .overrange    (overrange),
        .peak_max     (peak_max),
        .peak_min     (peak_min)
    );

    // ADC model: a new conversion result appears after each rising adc_clk.
    always @(posedge adc_clk) begin
        #1;
        adc_data = src_mem[k];
        adc_otr  = otr_mem[k];
        k = k + 1;
    end

    always @(posedge clk) begin
        if (!reset && sample_valid && sample_ready) got_q.push_back(sample);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; clear_stats = 1'b0; sample_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_run(input logic ready);
        k = 0; t = 0;
        got_q.delete();
        sample_ready = ready;
        enable = 1'b1;
    endtask

    task automatic fill(input bit ramp);
        for (int i = 0; i < 256; i++) begin
            src_mem[i] = ramp ? DATA_W'(i) : DATA_W'($urandom_range(0, 1023));
            otr_mem[i] = 1'b0;
        end
    endtask

    task automatic check_drain(input string tag, input int first, input int n);
        check({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(src_mem[first + i]));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_adc_clk"},   32'(adc_clk),      32'(0));
        check({tag, "_valid"},     32'(sample_valid), 32'(0));
        check({tag, "_sample"},    32'(sample),       32'(0));
        check({tag, "_overflow"},  32'(overflow),     32'(0));
        check({tag, "_overrange"}, 32'(overrange),    32'(0));
        check({tag, "_peak_max"},  32'(peak_max),     32'(0));
        check({tag, "_peak_min"},  32'(peak_min),     32'(10'h3ff));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear_stats = 1'b0; sample_ready = 1'b0;
        adc_data = '0; adc_otr = 1'b0;
        fill(1'b1);
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        // Start-up flush with a ramp: 2-high/2-low clock, first pop is value 5.
        start_run(1'b1);
        for (int j = 1; j <= 8; j++) begin
            goto(j);
            check("adc_clk_wave", 32'(adc_clk), 32'(((j - 1) % CLK_DIV) < (CLK_DIV / 2)));
        end
        goto(62); enable = 1'b0;
        goto(72);
        check_drain("ramp", PIPE_LAT, 10);
        check("ramp_idle_clk", 32'(adc_clk), 32'(0));
        check("ramp_empty", 32'(sample_valid), 32'(0));

        // Overflow with the consumer stalled for 20 run strobes.
        do_reset(); start_run(1'b0);
        goto(86);
        check("ovf_at_16", 32'(overflow), 32'(0));
        check("full_head", 32'(sample), 32'(src_mem[PIPE_LAT]));
        goto(90);
        check("ovf_at_17", 32'(overflow), 32'(1));
        goto(102); enable = 1'b0;
        goto(104); sample_ready = 1'b1;
        goto(130);
        check_drain("ovf_drain", PIPE_LAT, FIFO_DEPTH);
        check("ovf_empty", 32'(sample_valid), 32'(0));
        check("ovf_sticky", 32'(overflow), 32'(1));

        // Full FIFO with a pop coinciding with the push of a new capture.
        do_reset(); start_run(1'b0);
        goto(89);
        check("fp_head", 32'(sample), 32'(src_mem[PIPE_LAT]));
        sample_ready = 1'b1;
        goto(90);
        sample_ready = 1'b0; enable = 1'b0;
        check("fp_overflow", 32'(overflow), 32'(0));
        check("fp_next_head", 32'(sample), 32'(src_mem[PIPE_LAT + 1]));
        goto(100); sample_ready = 1'b1;
        goto(125);
        check_drain("fp_drain", PIPE_LAT, FIFO_DEPTH + 1);
        check("fp_overflow_end", 32'(overflow), 32'(0));

        // Peaks, clear coinciding with a capture, and overrange stickiness.
        do_reset(); fill(1'b0);
        src_mem[5] = 10'd300; src_mem[6] = 10'd12; src_mem[7] = 10'd1023;
        src_mem[8] = 10'd7;   src_mem[9] = 10'd500;
        otr_mem[2] = 1'b1; otr_mem[12] = 1'b1;
        start_run(1'b1);
        goto(37);
        check("pk_max", 32'(peak_max), 32'(1023));
        check("pk_min", 32'(peak_min), 32'(7));
        check("otr_flush", 32'(overrange), 32'(0));
        goto(40); clear_stats = 1'b1;
        goto(41); clear_stats = 1'b0;
        check("clr_max", 32'(peak_max), 32'(500));
        check("clr_min", 32'(peak_min), 32'(500));
        check("clr_overflow", 32'(overflow), 32'(0));
        goto(49);
        check("otr_before", 32'(overrange), 32'(0));
        goto(53);
        check("otr_set", 32'(overrange), 32'(1));
        goto(81); enable = 1'b0;
        exp_max = 0; exp_min = 1023;
        for (int i = 9; i <= 19; i++) begin
            if (int'(src_mem[i]) > exp_max) exp_max = int'(src_mem[i]);
            if (int'(src_mem[i]) < exp_min) exp_min = int'(src_mem[i]);
        end
        check("rnd_max", 32'(peak_max), 32'(exp_max));
        check("rnd_min", 32'(peak_min), 32'(exp_min));
        check("otr_sticky", 32'(overrange), 32'(1));
        goto(95);
        check_drain("rnd_drain", PIPE_LAT, 15);

        // Disable on a strobe cycle with samples queued: they still drain.
        do_reset(); fill(1'b0); start_run(1'b0);
        goto(32); enable = 1'b0;
        goto(34);
        check("dis_clk", 32'(adc_clk), 32'(0));
        check("dis_valid", 32'(sample_valid), 32'(1));
        goto(40);
        check("dis_clk_held", 32'(adc_clk), 32'(0));
        sample_ready = 1'b1;
        goto(50);
        check_drain("dis_drain", PIPE_LAT, 3);
        check("dis_empty", 32'(sample_valid), 32'(0));

        // Reset in the middle of a run with sticky flags set.
        do_reset(); fill(1'b0); otr_mem[6] = 1'b1; start_run(1'b0);
        goto(97);
        check("pre_rst_ovf", 32'(overflow), 32'(1));
        check("pre_rst_otr", 32'(overrange), 32'(1));
        check("pre_rst_clk", 32'(adc_clk), 32'(1));
        reset = 1'b1; enable = 1'b0;
        goto(98);
        check_reset_values("midrst");
        reset = 1'b0;
        goto(103);
        check("post_rst_empty", 32'(sample_valid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
